au_transfer_ctrl: RTL and testbench

//  Arbitrates N requesters for one shared Align Unit and sequences each transfer through it. Latches a

---
 rtl/au_ctrl_pkg.sv | 15 +
 rtl/au_transfer_ctrl_if.sv | 58 +++++
 rtl/au_transfer_ctrl_rr_arbiter.sv | 31 +++
 rtl/au_transfer_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_au_transfer_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/au_ctrl_pkg.sv
// Shared types and constants for the align-unit transfer controller.
// Imported by the interface, arbiter and controller top.
package au_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } t_au_state;

  localparam int WORD_BYTES = 8;
  localparam int OFFS_WIDTH = 3;
  localparam int DATA_WIDTH = 64;

endpackage

// File: rtl/au_transfer_ctrl_if.sv
// Requester-side and align-unit-side signals of the transfer controller.
// master = controller, slave = requesters plus align unit.
interface au_transfer_ctrl_if
  import au_ctrl_pkg::*;
#(
  parameter int REQUESTERS = 2,
  parameter int LEN_WIDTH  = 12
);

  localparam int N  = REQUESTERS;
  localparam int OW = OFFS_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic [N-1:0]           RQ_REQ;
  logic [OW*N-1:0]        RQ_SRC_ADDR;
  logic [OW*N-1:0]        RQ_DST_ADDR;
  logic [LEN_WIDTH*N-1:0] RQ_LEN;
  logic [N-1:0]           RQ_GRANT;
  logic [DW*N-1:0]        RQ_DATA;
  logic [N-1:0]           RQ_SRC_RDY;
  logic [N-1:0]           RQ_DST_RDY;
  logic [N-1:0]           RQ_DONE;

  logic [OW-1:0]          AU_SRC_ADDR;
  logic [OW-1:0]          AU_DST_ADDR;
  logic [OW-1:0]          AU_DATA_LEN;
  logic [DW-1:0]          AU_IN_DATA;
  logic                   AU_IN_SOF;
  logic                   AU_IN_EOF;
  logic                   AU_IN_SRC_RDY;
  logic                   AU_IN_DST_RDY;
  logic                   AU_OUT_EOF;
  logic                   AU_OUT_SRC_RDY;
  logic                   AU_OUT_DST_RDY;

  modport master (
    input  RQ_REQ, RQ_SRC_ADDR, RQ_DST_ADDR,
    input  RQ_LEN, RQ_DATA, RQ_SRC_RDY,
    output RQ_GRANT, RQ_DST_RDY, RQ_DONE,
    output AU_SRC_ADDR, AU_DST_ADDR, AU_DATA_LEN,
    output AU_IN_DATA, AU_IN_SOF, AU_IN_EOF,
    output AU_IN_SRC_RDY,
    input  AU_IN_DST_RDY,
    input  AU_OUT_EOF, AU_OUT_SRC_RDY, AU_OUT_DST_RDY
  );

  modport slave (
    output RQ_REQ, RQ_SRC_ADDR, RQ_DST_ADDR,
    output RQ_LEN, RQ_DATA, RQ_SRC_RDY,
    input  RQ_GRANT, RQ_DST_RDY, RQ_DONE,
    input  AU_SRC_ADDR, AU_DST_ADDR, AU_DATA_LEN,
    input  AU_IN_DATA, AU_IN_SOF, AU_IN_EOF,
    input  AU_IN_SRC_RDY,
    output AU_IN_DST_RDY,
    output AU_OUT_EOF, AU_OUT_SRC_RDY, AU_OUT_DST_RDY
  );

endinterface

// File: rtl/au_transfer_ctrl_rr_arbiter.sv
// Round-robin pick: first set request at or after the pointer.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int PW         = $clog2(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] req_i,
  input  logic [PW-1:0]         ptr_i,
  output logic [REQUESTERS-1:0] gnt_o,
  output logic [PW-1:0]         idx_o,
  output logic                  any_o
);

  int k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int i = 0; i < REQUESTERS; i++) begin
      k = (int'(ptr_i) + i) % REQUESTERS;
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        idx_o    = PW'(k);
        gnt_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/au_transfer_ctrl.sv
// Arbitrates requesters onto one align unit and sequences each frame
// through it, holding the grant until the aligned EOF leaves the unit.
module au_transfer_ctrl
  import au_ctrl_pkg::*;
#(
  parameter int REQUESTERS = 2,
  parameter int LEN_WIDTH  = 12
) (
  input  logic               CLK,
  input  logic               RESET,
  au_transfer_ctrl_if.master bus,
  output logic               BUSY
);

  localparam int N  = REQUESTERS;
  localparam int PW = $clog2(REQUESTERS);
  localparam int CW = LEN_WIDTH + 1;
  localparam int SW = LEN_WIDTH + 2;
  localparam int OW = OFFS_WIDTH;
  localparam int DW = DATA_WIDTH;

  t_au_state     state_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] gidx_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] words_q;
  logic [OW-1:0] src_q;
  logic [OW-1:0] dst_q;
  logic [OW-1:0] len_q;
  logic [N-1:0]  grant_q;
  logic [N-1:0]  done_q;

  logic [N-1:0]  arb_gnt;
  logic [PW-1:0] arb_idx;
  logic          arb_any;

  rr_arbiter #(
    .REQUESTERS(N),
    .PW        (PW)
  ) u_arb (
    .req_i(bus.RQ_REQ),
    .ptr_i(ptr_q),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx),
    .any_o(arb_any)
  );

  logic [OW-1:0]        src_sel;
  logic [OW-1:0]        dst_sel;
  logic [LEN_WIDTH-1:0] len_sel;
  logic [SW-1:0]        span;
  logic [CW-1:0]        words_d;
  logic [PW-1:0]        ptr_d;
  logic                 arb_go;

  always_comb begin
    src_sel = bus.RQ_SRC_ADDR[arb_idx*OW +: OW];
    dst_sel = bus.RQ_DST_ADDR[arb_idx*OW +: OW];
    len_sel = bus.RQ_LEN[arb_idx*LEN_WIDTH +: LEN_WIDTH];
    span    = SW'(src_sel) + SW'(len_sel)
            + SW'(WORD_BYTES - 1);
    words_d = CW'(span >> 3);
    ptr_d   = (arb_idx == PW'(N - 1))
            ? '0 : arb_idx + PW'(1);
  end

  // A pending grant pulse blocks arbitration: the winner still holds REQ.
  assign arb_go = (state_q == IDLE) && arb_any
                && (grant_q == '0);

  logic [DW-1:0] g_data;
  logic          g_srdy;
  logic          xfer;
  logic          last;
  logic          out_fire;
  logic [N-1:0]  g_dec;

  always_comb begin
    g_data   = bus.RQ_DATA[gidx_q*DW +: DW];
    g_srdy   = bus.RQ_SRC_RDY[gidx_q];
    xfer     = (state_q == RUN) && g_srdy
             && bus.AU_IN_DST_RDY;
    last     = (cnt_q == words_q - CW'(1));
    out_fire = bus.AU_OUT_EOF && bus.AU_OUT_SRC_RDY
             && bus.AU_OUT_DST_RDY;
    g_dec         = '0;
    g_dec[gidx_q] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      words_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (arb_go) begin
            grant_q <= arb_gnt;
            gidx_q  <= arb_idx;
            ptr_q   <= ptr_d;
            src_q   <= src_sel;
            dst_q   <= dst_sel;
            len_q   <= len_sel[OW-1:0];
            cnt_q   <= '0;
            words_q <= words_d;
            if (len_sel == '0) done_q  <= arb_gnt;
            else               state_q <= RUN;
          end else begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
              if (out_fire) begin
                state_q <= IDLE;
                done_q  <= g_dec;
              end else begin
                state_q <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            state_q <= IDLE;
            done_q  <= g_dec;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [N-1:0]  dst_rdy;
  logic [DW-1:0] in_data;
  logic          in_sof;
  logic          in_eof;
  logic          in_srdy;

  always_comb begin
    dst_rdy = '0;
    in_data = '0;
    in_sof  = 1'b0;
    in_eof  = 1'b0;
    in_srdy = 1'b0;
    if (state_q == RUN) begin
      dst_rdy[gidx_q] = bus.AU_IN_DST_RDY;
      in_data = g_data;
      in_sof  = (cnt_q == '0);
      in_eof  = last;
      in_srdy = g_srdy;
    end
  end

  assign bus.RQ_GRANT      = grant_q;
  assign bus.RQ_DONE       = done_q;
  assign bus.RQ_DST_RDY    = dst_rdy;
  assign bus.AU_SRC_ADDR   = src_q;
  assign bus.AU_DST_ADDR   = dst_q;
  assign bus.AU_DATA_LEN   = len_q;
  assign bus.AU_IN_DATA    = in_data;
  assign bus.AU_IN_SOF     = in_sof;
  assign bus.AU_IN_EOF     = in_eof;
  assign bus.AU_IN_SRC_RDY = in_srdy;
  assign BUSY              = (state_q != IDLE);

endmodule

// File: tb/tb_au_transfer_ctrl.sv
// Directed bench for au_transfer_ctrl with two requesters.
// Drives after each rising edge, samples before the next.
module tb_au_transfer_ctrl;

  logic clk;
  logic rst_n;
  logic busy;

  au_transfer_ctrl_if #(
    .REQUESTERS(2),
    .LEN_WIDTH (12)
  ) bus ();

  au_transfer_ctrl #(
    .REQUESTERS(2),
    .LEN_WIDTH (12)
  ) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bus),
    .BUSY (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input int i,
                        input logic [2:0] src,
                        input logic [2:0] dst,
                        input logic [11:0] len);
    bus.RQ_SRC_ADDR[i*3 +: 3] = src;
    bus.RQ_DST_ADDR[i*3 +: 3] = dst;
    bus.RQ_LEN[i*12 +: 12]    = len;
  endtask

  task automatic set_out(input logic v);
    bus.AU_OUT_EOF     = v;
    bus.AU_OUT_SRC_RDY = v;
    bus.AU_OUT_DST_RDY = v;
  endtask

  logic [1:0] exp_g [6];
  logic [1:0] exp_d [6];
  logic       exp_b [6];
  int         sent;
  logic       sr;
  logic       dr;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.RQ_REQ        = '0;
    bus.RQ_SRC_ADDR   = '0;
    bus.RQ_DST_ADDR   = '0;
    bus.RQ_LEN        = '0;
    bus.RQ_DATA       = '0;
    bus.RQ_SRC_RDY    = '0;
    bus.AU_IN_DST_RDY = 1'b0;
    set_out(1'b0);
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_grant", bus.RQ_GRANT, 0);
    chk("rst_done", bus.RQ_DONE, 0);
    chk("rst_srdy", bus.AU_IN_SRC_RDY, 0);
    chk("rst_src", bus.AU_SRC_ADDR, 0);
    rst_n = 1'b1;
    step();

    // single word, SOF=EOF together
    set_rq(0, 3'd0, 3'd0, 12'd8);
    bus.RQ_DATA[63:0]  = 64'h1111_2222_3333_4444;
    bus.RQ_SRC_RDY     = 2'b11;
    bus.AU_IN_DST_RDY  = 1'b1;
    bus.RQ_REQ         = 2'b01;
    #1;
    chk("t1_pre_grant", bus.RQ_GRANT, 0);
    chk("t1_pre_busy", busy, 0);
    step();
    chk("t1_grant", bus.RQ_GRANT, 2'b01);
    chk("t1_busy", busy, 1);
    chk("t1_srdy", bus.AU_IN_SRC_RDY, 1);
    chk("t1_sof", bus.AU_IN_SOF, 1);
    chk("t1_eof", bus.AU_IN_EOF, 1);
    chk("t1_data", bus.AU_IN_DATA, 64'h1111_2222_3333_4444);
    chk("t1_dstrdy", bus.RQ_DST_RDY, 2'b01);
    chk("t1_dlen", bus.AU_DATA_LEN, 0);
    bus.RQ_REQ = 2'b00;
    step();
    chk("t1_drain_srdy", bus.AU_IN_SRC_RDY, 0);
    chk("t1_drain_busy", busy, 1);
    chk("t1_drain_done", bus.RQ_DONE, 0);
    set_out(1'b1);
    step();
    chk("t1_done", bus.RQ_DONE, 2'b01);
    chk("t1_done_busy", busy, 0);
    set_out(1'b0);
    step();
    chk("t1_done_clr", bus.RQ_DONE, 0);

    // four words: SRC=5 LEN=20
    set_rq(1, 3'd5, 3'd2, 12'd20);
    bus.RQ_REQ = 2'b10;
    step();
    chk("t2_grant", bus.RQ_GRANT, 2'b10);
    chk("t2_src", bus.AU_SRC_ADDR, 5);
    chk("t2_dst", bus.AU_DST_ADDR, 2);
    chk("t2_dlen", bus.AU_DATA_LEN, 4);
    bus.RQ_REQ = 2'b00;
    for (int w = 0; w < 4; w++) begin
      bus.RQ_DATA[127:64] = 64'hA0 + 64'(w);
      #1;
      chk($sformatf("t2_sof%0d", w),
          bus.AU_IN_SOF, (w == 0));
      chk($sformatf("t2_eof%0d", w),
          bus.AU_IN_EOF, (w == 3));
      chk($sformatf("t2_data%0d", w),
          bus.AU_IN_DATA, 64'hA0 + 64'(w));
      step();
    end
    chk("t2_drain_busy", busy, 1);
    chk("t2_drain_srdy", bus.AU_IN_SRC_RDY, 0);
    chk("t2_drain_src", bus.AU_SRC_ADDR, 5);
    step();
    chk("t2_wait_done", bus.RQ_DONE, 0);
    set_out(1'b1);
    step();
    chk("t2_done", bus.RQ_DONE, 2'b10);
    chk("t2_done_src", bus.AU_SRC_ADDR, 5);
    chk("t2_done_dst", bus.AU_DST_ADDR, 2);
    set_out(1'b0);
    step();
    chk("t2_idle_src", bus.AU_SRC_ADDR, 0);

    // alternation with both requests held
    set_rq(0, 3'd0, 3'd0, 12'd8);
    set_rq(1, 3'd0, 3'd0, 12'd8);
    set_out(1'b1);
    exp_g = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    exp_d = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    exp_b = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bus.RQ_REQ = 2'b11;
    step();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t3_grant%0d", k),
          bus.RQ_GRANT, exp_g[k]);
      chk($sformatf("t3_done%0d", k),
          bus.RQ_DONE, exp_d[k]);
      chk($sformatf("t3_busy%0d", k), busy, exp_b[k]);
      if (k == 5) bus.RQ_REQ = 2'b00;
      step();
    end
    set_out(1'b0);
    chk("t3_end_busy", busy, 0);
    chk("t3_end_grant", bus.RQ_GRANT, 0);

    // random stalls: SRC=3 LEN=29 -> 4 words
    set_rq(0, 3'd3, 3'd1, 12'd29);
    bus.RQ_REQ = 2'b01;
    step();
    chk("t4_grant", bus.RQ_GRANT, 2'b01);
    bus.RQ_REQ = 2'b00;
    sent = 0;
    for (int c = 0; c < 200 && sent < 4; c++) begin
      sr = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      bus.RQ_SRC_RDY[0] = sr;
      bus.AU_IN_DST_RDY = dr;
      bus.RQ_DATA[63:0] = 64'hD000 + 64'(sent);
      #1;
      chk("t4_dstrdy", bus.RQ_DST_RDY, {1'b0, dr});
      if (sr && dr) begin
        chk("t4_data", bus.AU_IN_DATA,
            64'hD000 + 64'(sent));
        chk("t4_sof", bus.AU_IN_SOF, (sent == 0));
        chk("t4_eof", bus.AU_IN_EOF, (sent == 3));
        sent++;
      end
      step();
    end
    chk("t4_words", sent, 4);
    chk("t4_drain_busy", busy, 1);
    chk("t4_drain_srdy", bus.AU_IN_SRC_RDY, 0);
    bus.RQ_SRC_RDY    = 2'b11;
    bus.AU_IN_DST_RDY = 1'b1;
    set_out(1'b1);
    step();
    chk("t4_done", bus.RQ_DONE, 2'b01);
    set_out(1'b0);
    step();

    // zero length: grant and done together, no frame
    set_rq(0, 3'd2, 3'd4, 12'd0);
    bus.RQ_REQ = 2'b01;
    step();
    chk("t5_grant", bus.RQ_GRANT, 2'b01);
    chk("t5_done", bus.RQ_DONE, 2'b01);
    chk("t5_busy", busy, 0);
    chk("t5_srdy", bus.AU_IN_SRC_RDY, 0);
    step();
    chk("t5_no_regrant", bus.RQ_GRANT, 0);
    chk("t5_done_clr", bus.RQ_DONE, 0);
    chk("t5_srdy2", bus.AU_IN_SRC_RDY, 0);
    bus.RQ_REQ = 2'b00;
    step();
    chk("t5_idle_busy", busy, 0);

    // reset during word 2 of 4
    set_rq(0, 3'd0, 3'd3, 12'd8);
    set_rq(1, 3'd0, 3'd6, 12'd32);
    bus.RQ_REQ = 2'b10;
    step();
    chk("t6_grant", bus.RQ_GRANT, 2'b10);
    bus.RQ_REQ = 2'b00;
    step();
    step();
    rst_n      = 1'b0;
    bus.RQ_REQ = 2'b11;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_srdy", bus.AU_IN_SRC_RDY, 0);
    chk("t6_rst_dst", bus.AU_DST_ADDR, 0);
    chk("t6_rst_dstrdy", bus.RQ_DST_RDY, 0);
    step();
    chk("t6_rst_grant", bus.RQ_GRANT, 0);
    chk("t6_rst_busy2", busy, 0);
    rst_n = 1'b1;
    step();
    chk("t6_ptr0_grant", bus.RQ_GRANT, 2'b01);
    chk("t6_ptr0_dst", bus.AU_DST_ADDR, 3);
    bus.RQ_REQ = 2'b00;
    set_out(1'b1);
    step();
    step();
    set_out(1'b0);
    chk("t6_end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
